grid_serial_link: RTL and testbench

Host-side serial link controller for the system memory's serial port. It serializes a parallel host word into the memory's serial load path by driving LOAD_MODE and the serial data line. It also reads the memory back by driving OUTPUT_MODE and deserializing the rotated serial output into a parallel word. The block sits between the host/IO logic and the system memory; it never drives RUN_MODE, and BUSY lets the top level keep RUN_MODE low while a transfer is in progress.

---
 rtl/grid_serial_link.sv | 115 +++++++++++
 tb/tb_grid_serial_link.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_serial_link.sv
// grid_serial_link
//   Host-side serial link to the system memory's serial port.
//   Write: a parallel host word is shifted MSB first into the memory through
//   its load path (LOAD_MODE + MEM_SERIAL_IN).
//   Read:  the memory is rotated DATA_SIZE times with OUTPUT_MODE. The
//   registered SERIAL_OUT bits are gathered into a parallel word. The memory
//   ends up holding the same word it held before the read.
// Ports
//   CLK, RESET      clock, synchronous active-high reset
//   TX_DATA/VALID   write request; accepted only while TX_READY (IDLE)
//   TX_READY        high in IDLE
//   RX_REQ          level readback request, sampled in IDLE (a write wins)
//   RX_DATA/VALID   last word read back, and a 1-cycle pulse on update
//   BUSY            high outside IDLE; the top level keeps RUN_MODE low on it
//   MEM_SERIAL_IN, LOAD_MODE, OUTPUT_MODE  to the memory, state-decoded
//   MEM_SERIAL_OUT  registered serial output from the memory
module grid_serial_link #(
  parameter int DATA_SIZE = 5
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_SIZE-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  input  logic                 RX_REQ,
  output logic [DATA_SIZE-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 BUSY,
  output logic                 MEM_SERIAL_IN,
  output logic                 LOAD_MODE,
  output logic                 OUTPUT_MODE,
  input  logic                 MEM_SERIAL_OUT
);

  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD, CAPTURE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [DATA_SIZE-1:0] tx_shreg, tx_shreg_nxt;
  logic [DATA_SIZE-1:0] rx_shreg, rx_shreg_nxt;
  logic [DATA_SIZE-1:0] rx_data, rx_data_nxt;
  logic                 rx_valid, rx_valid_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_shreg <= '0;
      rx_shreg <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tx_shreg <= tx_shreg_nxt;
      rx_shreg <= rx_shreg_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    tx_shreg_nxt = tx_shreg;
    rx_shreg_nxt = rx_shreg;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (TX_VALID) begin
          tx_shreg_nxt = TX_DATA;
          cnt_nxt      = '0;
          state_nxt    = LOAD;
        end else if (RX_REQ) begin
          cnt_nxt   = '0;
          state_nxt = UNLOAD;
        end
      end
      LOAD: begin
        tx_shreg_nxt = {tx_shreg[DATA_SIZE-2:0], 1'b0};
        cnt_nxt      = cnt + CW'(1);
        if (cnt == LAST) state_nxt = IDLE;
      end
      UNLOAD: begin
        cnt_nxt = cnt + CW'(1);
        // SERIAL_OUT is registered, so the first rotation's bit only shows
        // up one edge later; the edge at cnt==0 has nothing valid to take.
        if (cnt != '0) rx_shreg_nxt = {rx_shreg[DATA_SIZE-2:0], MEM_SERIAL_OUT};
        if (cnt == LAST) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // Rotation has stopped; this picks up the bit from the last rotation.
        rx_shreg_nxt = {rx_shreg[DATA_SIZE-2:0], MEM_SERIAL_OUT};
        rx_data_nxt  = {rx_shreg[DATA_SIZE-2:0], MEM_SERIAL_OUT};
        rx_valid_nxt = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // All memory-facing controls decode flops only: no input-to-output path.
  assign TX_READY      = (state == IDLE);
  assign BUSY          = (state != IDLE);
  assign LOAD_MODE     = (state == LOAD);
  assign OUTPUT_MODE   = (state == UNLOAD);
  assign MEM_SERIAL_IN = (state == LOAD) & tx_shreg[DATA_SIZE-1];
  assign RX_DATA       = rx_data;
  assign RX_VALID      = rx_valid;

endmodule

// File: tb/tb_grid_serial_link.sv
// Testbench for grid_serial_link with a behavioural model of the system
// memory serial port. The reference is a transaction-level "word the memory
// holds": a write sets it, and a read must return it without changing it.
module tb_grid_serial_link;
  localparam int N = 5;

  logic         CLK = 1'b0;
  logic         RESET, TX_VALID, RX_REQ;
  logic [N-1:0] TX_DATA;
  logic         TX_READY, RX_VALID, BUSY, MEM_SERIAL_IN, LOAD_MODE, OUTPUT_MODE;
  logic [N-1:0] RX_DATA;
  wire          MEM_SERIAL_OUT;

  grid_serial_link #(.DATA_SIZE(N)) dut (
    .CLK(CLK), .RESET(RESET), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .RX_REQ(RX_REQ), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .BUSY(BUSY), .MEM_SERIAL_IN(MEM_SERIAL_IN), .LOAD_MODE(LOAD_MODE),
    .OUTPUT_MODE(OUTPUT_MODE), .MEM_SERIAL_OUT(MEM_SERIAL_OUT)
  );

  always #5 CLK = ~CLK;

  // Memory serial port: load shifts in at the LSB, output mode rotates left
  // with the bit leaving the MSB registered onto SERIAL_OUT.
  logic [N-1:0] mem = '0;
  logic         mem_so = 1'b0;
  logic         pre_en = 1'b0;
  logic [N-1:0] pre_val = '0;
  always @(posedge CLK) begin
    if (pre_en) mem <= pre_val;
    else if (LOAD_MODE) mem <= {mem[N-2:0], MEM_SERIAL_IN};
    else if (OUTPUT_MODE) begin
      mem    <= {mem[N-2:0], mem[N-1]};
      mem_so <= mem[N-1];
    end
  end
  assign MEM_SERIAL_OUT = mem_so;

  // Whole-run invariants, checked once at the end.
  bit overlap_seen = 1'b0, dbl_seen = 1'b0, prev_rxv = 1'b0;
  always @(negedge CLK) begin
    if (LOAD_MODE && OUTPUT_MODE) overlap_seen <= 1'b1;
    if (RX_VALID && prev_rxv) dbl_seen <= 1'b1;
    prev_rxv <= RX_VALID;
  end

  int n_chk = 0, n_pass = 0;
  logic [N-1:0] model_word;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!TX_READY && k < 50) begin @(negedge CLK); k++; end
    if (k >= 50) chk("ready_timeout", 1, 0);
  endtask

  // Write d; exp_bits is the serial pattern expected on MEM_SERIAL_IN,
  // first bit in the MSB position.
  task automatic do_write(input logic [N-1:0] d, input logic [N-1:0] exp_bits);
    logic [N-1:0] bits = '0;
    int lm = 0, rdy = 0;
    wait_ready();
    TX_DATA = d; TX_VALID = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge CLK);
      if (i == 0) TX_VALID = 1'b0;
      lm += int'(LOAD_MODE);
      rdy += int'(TX_READY);
      bits = {bits[N-2:0], MEM_SERIAL_IN};
    end
    @(negedge CLK);
    chk("wr_bits", int'(bits), int'(exp_bits));
    chk("wr_load_cycles", lm, N);
    chk("wr_ready_low", rdy, 0);
    chk("wr_load_done", int'(LOAD_MODE), 0);
    chk("wr_ready_back", int'(TX_READY), 1);
    chk("wr_mem", int'(mem), int'(d));
  endtask

  // Read back, expecting exp. poke pulses TX_VALID mid-UNLOAD.
  task automatic do_read(input logic [N-1:0] exp, input bit poke);
    int om = 0, lm = 0;
    wait_ready();
    RX_REQ = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge CLK);
      if (i == 0) RX_REQ = 1'b0;
      if (poke && i == 1) begin TX_DATA = 5'b10101; TX_VALID = 1'b1; end
      if (poke && i == 2) TX_VALID = 1'b0;
      om += int'(OUTPUT_MODE);
      lm += int'(LOAD_MODE);
    end
    @(negedge CLK);
    chk("rd_capture_om", int'(OUTPUT_MODE), 0);
    chk("rd_capture_rxv", int'(RX_VALID), 0);
    chk("rd_capture_busy", int'(BUSY), 1);
    @(negedge CLK);
    chk("rd_rxv", int'(RX_VALID), 1);
    chk("rd_data", int'(RX_DATA), int'(exp));
    chk("rd_idle", int'(TX_READY), 1);
    @(negedge CLK);
    chk("rd_rxv_pulse", int'(RX_VALID), 0);
    chk("rd_data_held", int'(RX_DATA), int'(exp));
    chk("rd_om_cycles", om, N);
    chk("rd_no_load", lm, 0);
    chk("rd_nondestructive", int'(mem), int'(exp));
  endtask

  typedef struct {
    logic [N-1:0] wdata;
    logic [N-1:0] exp_bits;
    logic [N-1:0] exp_rx;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{5'b10110, 5'b10110, 5'b10110};
    vecs[1] = '{5'b00000, 5'b00000, 5'b00000};
    vecs[2] = '{5'b11111, 5'b11111, 5'b11111};
    vecs[3] = '{5'b10000, 5'b10000, 5'b10000};
    vecs[4] = '{5'b00001, 5'b00001, 5'b00001};
    vecs[5] = '{5'b01010, 5'b01010, 5'b01010};

    // Reset with a write request pending.
    RESET = 1'b1; TX_VALID = 1'b1; TX_DATA = 5'b11111; RX_REQ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0; TX_VALID = 1'b0;
    chk("rst_ready", int'(TX_READY), 1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_load", int'(LOAD_MODE), 0);
    chk("rst_om", int'(OUTPUT_MODE), 0);
    chk("rst_sin", int'(MEM_SERIAL_IN), 0);
    chk("rst_rxdata", int'(RX_DATA), 0);
    chk("rst_rxv", int'(RX_VALID), 0);
    @(negedge CLK);
    chk("rst_no_load", int'(LOAD_MODE), 0);

    // Readback of a preloaded memory.
    pre_val = 5'b01101; pre_en = 1'b1;
    @(negedge CLK);
    pre_en = 1'b0;
    chk("preload", int'(mem), 13);
    do_read(5'b01101, 1'b0);
    model_word = 5'b01101;

    // Vector table: write then read back each word.
    foreach (vecs[i]) begin
      do_write(vecs[i].wdata, vecs[i].exp_bits);
      do_read(vecs[i].exp_rx, 1'b0);
      model_word = vecs[i].wdata;
    end

    // Write and read requested on the same edge: write first.
    begin
      logic [N-1:0] bits = '0;
      int lm = 0, om = 0;
      wait_ready();
      TX_DATA = 5'b11001; TX_VALID = 1'b1; RX_REQ = 1'b1;
      for (int i = 0; i < N; i++) begin
        @(negedge CLK);
        if (i == 0) TX_VALID = 1'b0;
        lm += int'(LOAD_MODE);
        om += int'(OUTPUT_MODE);
        bits = {bits[N-2:0], MEM_SERIAL_IN};
      end
      @(negedge CLK);
      chk("sim_bits", int'(bits), int'(5'b11001));
      chk("sim_load_cycles", lm, N);
      chk("sim_no_om", om, 0);
      chk("sim_idle_between", int'(TX_READY), 1);
      chk("sim_mem", int'(mem), int'(5'b11001));
      om = 0;
      for (int i = 0; i < N; i++) begin
        @(negedge CLK);
        if (i == 0) RX_REQ = 1'b0;
        om += int'(OUTPUT_MODE);
      end
      chk("sim_om_cycles", om, N);
      @(negedge CLK);
      @(negedge CLK);
      chk("sim_rxv", int'(RX_VALID), 1);
      chk("sim_rxdata", int'(RX_DATA), int'(5'b11001));
      model_word = 5'b11001;
    end

    // Reset after two LOAD cycles, then a clean write.
    wait_ready();
    TX_DATA = 5'b11111; TX_VALID = 1'b1;
    @(negedge CLK);
    TX_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mid_rst_load", int'(LOAD_MODE), 0);
    chk("mid_rst_ready", int'(TX_READY), 1);
    chk("mid_rst_rxdata", int'(RX_DATA), 0);
    chk("mid_rst_sin", int'(MEM_SERIAL_IN), 0);
    do_write(5'b00011, 5'b00011);
    do_read(5'b00011, 1'b0);
    model_word = 5'b00011;

    // TX_VALID pulsed during UNLOAD is dropped.
    do_read(model_word, 1'b1);
    @(negedge CLK);
    chk("busy_ignore_no_load", int'(LOAD_MODE), 0);
    chk("busy_ignore_mem", int'(mem), int'(model_word));

    // Random writes/reads against the held-word reference.
    for (int r = 0; r < 30; r++) begin
      logic [N-1:0] d;
      if ($urandom_range(0, 1) == 1) begin
        d = N'($urandom_range(0, (1 << N) - 1));
        do_write(d, d);
        model_word = d;
      end else begin
        do_read(model_word, 1'b0);
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    chk("modes_never_overlap", int'(overlap_seen), 0);
    chk("rxv_single_cycle", int'(dbl_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
